env_gen: RTL and testbench

ENV_GEN -- requirements
Module: env_gen

---
 rtl/env_gen.sv | 201 ++++++++++++++++++++
 tb/tb_env_gen.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/env_gen.sv
// -----------------------------------------------------------------------------
// env_gen -- ADSR envelope generator
//
// Purpose:
//   Produces a W-bit envelope level that walks through the phases
//   IDLE -> ATTACK -> DECAY -> SUSTAIN -> RELEASE -> IDLE.
//   The level steps only on cycles where the rate strobe tick_i is high.
//   Gate edges change the phase without waiting for a tick.
//   Every output is driven directly by a flop.
//
// Ports:
//   clk_i         in   1  system clock, rising edge
//   reset_n       in   1  asynchronous active-low reset
//   tick_i        in   1  one-cycle rate strobe; level steps only when high
//   gate_i        in   1  note gate (1 = key held, 0 = key released)
//   attack_step   in   W  increment per tick in ATTACK (0 = jump to full scale)
//   decay_step    in   W  decrement per tick in DECAY (0 = jump to sustain)
//   sustain_lvl   in   W  level held in SUSTAIN (followed every cycle)
//   release_step  in   W  decrement per tick in RELEASE (0 = jump to 0)
//   env_o         out  W  registered envelope level
//   state_o       out  3  phase: IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   busy_o        out  1  high in every phase except IDLE
//   done_o        out  1  one-cycle pulse when RELEASE reaches level 0
//
// Handshake:
//   There is no valid/ready pair. tick_i is a qualifier, not a handshake.
//   On each tick_i cycle the block samples the step and sustain inputs.
//   It makes at most one level step, and env_o shows the result one clock later.
//   A gate-driven phase change in the same cycle takes priority over the step.
//
// Configuration macro: ENV_GEN_RETRIG_EN
//   Defined   : gate_i=1 in RELEASE re-enters ATTACK from the current level.
//   Undefined : gate_i=1 in RELEASE is ignored until the release finishes.
//               A gate that is still high then restarts ATTACK from 0.
// -----------------------------------------------------------------------------
module env_gen #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_n,
  input  logic         tick_i,
  input  logic         gate_i,
  input  logic [W-1:0] attack_step,
  input  logic [W-1:0] decay_step,
  input  logic [W-1:0] sustain_lvl,
  input  logic [W-1:0] release_step,
  output logic [W-1:0] env_o,
  output logic [2:0]   state_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [W-1:0] FULL = {W{1'b1}};

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_level;
  logic [W-1:0] w_level_nxt;
  logic         r_busy;
  logic         w_busy_nxt;
  logic         r_done;
  logic         w_done_nxt;

  // Retrigger request: a held gate during RELEASE. It is tied off when the
  // feature is not built in, so RELEASE always runs to completion.
  logic w_retrig;
`ifdef ENV_GEN_RETRIG_EN
  assign w_retrig = gate_i;
`else
  assign w_retrig = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Candidate levels for one tick in each stepping phase.
  // ---------------------------------------------------------------------------

  // ATTACK: W+1-bit sum so a carry is seen as saturation, not as wrap-around.
  logic [W:0]   w_att_sum;
  logic         w_att_sat;
  logic [W-1:0] w_att_lvl;
  assign w_att_sum = {1'b0, r_level} + {1'b0, attack_step};
  assign w_att_sat = (attack_step == '0) || (w_att_sum >= {1'b0, FULL});
  assign w_att_lvl = w_att_sat ? FULL : w_att_sum[W-1:0];

  // DECAY: bit W of the difference flags an underflow.
  // The floor is sustain_lvl. Reaching the floor (or stepping past it) ends
  // DECAY. If sustain_lvl was raised above the current level, the level
  // snaps up to it.
  logic [W:0]   w_dec_diff;
  logic         w_dec_hit;
  logic [W-1:0] w_dec_lvl;
  assign w_dec_diff = {1'b0, r_level} - {1'b0, decay_step};
  assign w_dec_hit  = (decay_step == '0) || w_dec_diff[W] ||
                      (w_dec_diff[W-1:0] <= sustain_lvl);
  assign w_dec_lvl  = w_dec_hit ? sustain_lvl : w_dec_diff[W-1:0];

  // RELEASE: same underflow trick, with a floor of 0.
  logic [W:0]   w_rel_diff;
  logic         w_rel_hit;
  logic [W-1:0] w_rel_lvl;
  assign w_rel_diff = {1'b0, r_level} - {1'b0, release_step};
  assign w_rel_hit  = (release_step == '0) || w_rel_diff[W] ||
                      (w_rel_diff[W-1:0] == '0);
  assign w_rel_lvl  = w_rel_hit ? '0 : w_rel_diff[W-1:0];

  // ---------------------------------------------------------------------------
  // Process 1: state and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_level <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic.
  // A falling gate is checked before tick_i, so it wins over a same-cycle tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (gate_i) w_state_nxt = S_ATTACK;
      end
      S_ATTACK: begin
        if (!gate_i)                   w_state_nxt = S_RELEASE;
        else if (tick_i && w_att_sat)  w_state_nxt = S_DECAY;
      end
      S_DECAY: begin
        if (!gate_i)                   w_state_nxt = S_RELEASE;
        else if (tick_i && w_dec_hit)  w_state_nxt = S_SUSTAIN;
      end
      S_SUSTAIN: begin
        if (!gate_i)                   w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (w_retrig)                  w_state_nxt = S_ATTACK;
        else if (tick_i && w_rel_hit)  w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: next values for the registered outputs.
  // The level moves only on the paths that do not change phase because of the
  // gate. On a gate-driven change the level is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_level_nxt = r_level;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // ATTACK always starts from 0, even if a reset left stale data.
        w_level_nxt = '0;
      end
      S_ATTACK: begin
        if (gate_i && tick_i) w_level_nxt = w_att_lvl;
      end
      S_DECAY: begin
        if (gate_i && tick_i) w_level_nxt = w_dec_lvl;
      end
      S_SUSTAIN: begin
        // Follows sustain_lvl every cycle, with no tick needed.
        if (gate_i) w_level_nxt = sustain_lvl;
      end
      S_RELEASE: begin
        if (!w_retrig && tick_i) begin
          w_level_nxt = w_rel_lvl;
          w_done_nxt  = w_rel_hit;
        end
      end
      default: begin
        w_level_nxt = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign env_o   = r_level;
  assign state_o = r_state;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule

// File: tb/tb_env_gen.sv
// -----------------------------------------------------------------------------
// tb_env_gen -- self-checking bench for env_gen
//
// The reference model treats the envelope as an integer level with plain
// min/max arithmetic, following the phase rules of the generator.
// The bench runs directed scenarios with an expected-level queue, then a long
// randomized run that is checked against the model every cycle.
// -----------------------------------------------------------------------------
module tb_env_gen;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

`ifdef ENV_GEN_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk_i = 1'b0;
  logic         reset_n;
  logic         tick_i;
  logic         gate_i;
  logic [W-1:0] attack_step;
  logic [W-1:0] decay_step;
  logic [W-1:0] sustain_lvl;
  logic [W-1:0] release_step;
  logic [W-1:0] env_o;
  logic [2:0]   state_o;
  logic         busy_o;
  logic         done_o;

  always #5 clk_i = ~clk_i;

  env_gen #(.W(W)) dut (
    .clk_i        (clk_i),
    .reset_n      (reset_n),
    .tick_i       (tick_i),
    .gate_i       (gate_i),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_lvl  (sustain_lvl),
    .release_step (release_step),
    .env_o        (env_o),
    .state_o      (state_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  int m_phase = 0;
  int m_lvl   = 0;
  bit m_done  = 1'b0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Advance the model by one rising edge, using the inputs as driven now.
  task automatic model_clock();
    int nl;
    int np;
    int sus;
    nl  = m_lvl;
    np  = m_phase;
    sus = int'(sustain_lvl);
    m_done = 1'b0;
    case (m_phase)
      0: if (gate_i) begin np = 1; nl = 0; end
      1: if (!gate_i) np = 4;
         else if (tick_i) begin
           nl = (attack_step == 0) ? MAXV : imin(m_lvl + int'(attack_step), MAXV);
           if (nl == MAXV) np = 2;
         end
      2: if (!gate_i) np = 4;
         else if (tick_i) begin
           nl = (decay_step == 0) ? sus : imax(m_lvl - int'(decay_step), sus);
           if (nl == sus) np = 3;
         end
      3: if (!gate_i) np = 4;
         else nl = sus;
      default: if (RETRIG && gate_i) np = 1;
         else if (tick_i) begin
           nl = (release_step == 0) ? 0 : imax(m_lvl - int'(release_step), 0);
           if (nl == 0) begin np = 0; m_done = 1'b1; end
         end
    endcase
    m_lvl   = nl;
    m_phase = np;
  endtask

  // ---------------- driver tasks ----------------
  // One clock: the model updates on the edge, and the DUT is sampled 1 time
  // unit later. Inputs are changed only after this returns.
  task automatic step();
    @(posedge clk_i);
    model_clock();
    #1;
    check_val("env",   32'(env_o),   32'(m_lvl));
    check_val("state", 32'(state_o), 32'(m_phase));
    check_val("busy",  32'(busy_o),  32'(m_phase != 0));
    check_val("done",  32'(done_o),  32'(m_done));
  endtask

  // Issue one tick per queued expected level and compare each result.
  task automatic drain_ticks();
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick_i = 1'b1;
      step();
      tick_i = 1'b0;
      check_val("seq_env", 32'(env_o), 32'(e));
    end
  endtask

  // Assert reset in the middle of a cycle and check the asynchronous clear.
  task automatic apply_reset();
    reset_n = 1'b0;
    #2;
    check_val("rst_env",   32'(env_o),   32'h0);
    check_val("rst_state", 32'(state_o), 32'h0);
    check_val("rst_busy",  32'(busy_o),  32'h0);
    check_val("rst_done",  32'(done_o),  32'h0);
    m_phase = 0;
    m_lvl   = 0;
    m_done  = 1'b0;
    @(posedge clk_i);
    #1;
    check_val("rst_hold_done", 32'(done_o), 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic set_steps(input int a, input int d, input int s, input int r);
    attack_step  = W'(a);
    decay_step   = W'(d);
    sustain_lvl  = W'(s);
    release_step = W'(r);
  endtask

  // Drop the gate and finish the release in one tick.
  task automatic go_idle();
    gate_i = 1'b0;
    step();
    release_step = '0;
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    check_val("idle_state", 32'(state_o), 32'h0);
  endtask

  task automatic push_adsr_attack_decay();
    exp_q.push_back(8'h40); exp_q.push_back(8'h80);
    exp_q.push_back(8'hC0); exp_q.push_back(8'hFF);
    for (int v = 8'hEF; v >= 8'h8F; v -= 8'h10) exp_q.push_back(W'(v));
    exp_q.push_back(8'h80);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0;
    tick_i  = 1'b0;
    gate_i  = 1'b0;
    set_steps(0, 0, 0, 0);
    @(posedge clk_i);
    #1;
    apply_reset();

    // Full ADSR cycle.
    set_steps(8'h40, 8'h10, 8'h80, 8'h20);
    gate_i = 1'b1;
    step();
    check_val("adsr_attack_state", 32'(state_o), 32'd1);
    check_val("adsr_attack_start", 32'(env_o), 32'h0);
    push_adsr_attack_decay();
    drain_ticks();
    check_val("adsr_sustain_state", 32'(state_o), 32'd3);
    repeat (3) step();
    check_val("adsr_sustain_env", 32'(env_o), 32'h80);
    gate_i = 1'b0;
    step();
    check_val("adsr_release_state", 32'(state_o), 32'd4);
    exp_q.push_back(8'h60); exp_q.push_back(8'h40);
    exp_q.push_back(8'h20); exp_q.push_back(8'h00);
    drain_ticks();
    check_val("adsr_done_pulse", 32'(done_o), 32'h1);
    check_val("adsr_idle", 32'(state_o), 32'd0);
    step();
    check_val("adsr_done_single", 32'(done_o), 32'h0);

    // Attack saturation: 0xF0 + 0xF0 clamps to 0xFF instead of wrapping.
    set_steps(8'hF0, 8'h10, 8'h80, 8'h20);
    gate_i = 1'b1;
    step();
    exp_q.push_back(8'hF0); exp_q.push_back(8'hFF);
    drain_ticks();
    check_val("sat_decay_state", 32'(state_o), 32'd2);
    go_idle();

    // Early release: the gate falls in the same cycle as a tick, so no step.
    set_steps(8'h40, 8'h10, 8'h80, 8'h20);
    gate_i = 1'b1;
    step();
    exp_q.push_back(8'h40);
    drain_ticks();
    gate_i = 1'b0;
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    check_val("early_rel_state", 32'(state_o), 32'd4);
    check_val("early_rel_env", 32'(env_o), 32'h40);
    go_idle();

    // Zero steps jump directly.
    set_steps(0, 0, 8'h30, 0);
    gate_i = 1'b1;
    step();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h30);
    drain_ticks();
    check_val("zero_sustain_state", 32'(state_o), 32'd3);
    gate_i = 1'b0;
    step();
    check_val("zero_rel_env", 32'(env_o), 32'h30);
    exp_q.push_back(8'h00);
    drain_ticks();
    check_val("zero_done", 32'(done_o), 32'h1);
    step();

    // Retrigger during RELEASE at level 0x60.
    set_steps(8'h40, 8'h10, 8'h80, 8'h20);
    gate_i = 1'b1;
    step();
    push_adsr_attack_decay();
    drain_ticks();
    gate_i = 1'b0;
    step();
    exp_q.push_back(8'h60);
    drain_ticks();
    gate_i = 1'b1;
    step();
    check_val("retrig_env", 32'(env_o), 32'h60);
`ifdef ENV_GEN_RETRIG_EN
    check_val("retrig_state", 32'(state_o), 32'd1);
    exp_q.push_back(8'hA0);
    drain_ticks();
`else
    check_val("retrig_state", 32'(state_o), 32'd4);
    exp_q.push_back(8'h40); exp_q.push_back(8'h20); exp_q.push_back(8'h00);
    drain_ticks();
    check_val("retrig_done", 32'(done_o), 32'h1);
    step();
    check_val("retrig_restart_state", 32'(state_o), 32'd1);
    check_val("retrig_restart_env", 32'(env_o), 32'h0);
`endif
    go_idle();

    // Reset in the middle of ATTACK at level 0x40.
    set_steps(8'h40, 8'h10, 8'h80, 8'h20);
    gate_i = 1'b1;
    step();
    exp_q.push_back(8'h40);
    drain_ticks();
    gate_i = 1'b0;
    apply_reset();
    repeat (2) step();
    check_val("post_rst_idle", 32'(state_o), 32'd0);

    // Randomized run, checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        attack_step  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, MAXV));
        decay_step   = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, MAXV));
        release_step = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, MAXV));
        sustain_lvl  = ($urandom_range(0, 5) == 0) ? W'(MAXV) : W'($urandom_range(0, MAXV));
      end
      if ($urandom_range(0, 11) == 0) gate_i = ~gate_i;
      tick_i = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 399) == 0) begin
        apply_reset();
      end else begin
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
